// File: rtl/tlb_cp0_ctrl.sv
// tlb_cp0_ctrl
// CP0-side controller for a software-managed TLB.
// - Holds the Index, Random, EntryLo0, EntryLo1 and EntryHi registers.
// - Sequences TLBP / TLBR / TLBWI / TLBWR through an IDLE -> EXEC -> DONE
//   handshake.
// - Talks to the TLB array through its search, read and write ports.
module tlb_cp0_ctrl #(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,

    // operation handshake
    input  logic          op_valid,
    input  logic [1:0]    op_type,
    output logic          op_ready,
    output logic          op_done,

    // mtc0 / mfc0 access
    input  logic          mtc0_we,
    input  logic [4:0]    mtc0_addr,
    input  logic [31:0]   mtc0_wdata,
    input  logic [4:0]    mfc0_addr,
    output logic [31:0]   mfc0_rdata,

    // TLB search port
    output logic [18:0]   s_vpn2,
    output logic [7:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,

    // TLB read port
    output logic [IW-1:0] r_index,
    input  logic [18:0]   r_vpn2,
    input  logic [7:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_pfn0,
    input  logic [2:0]    r_c0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_pfn1,
    input  logic [2:0]    r_c1,
    input  logic          r_d1,
    input  logic          r_v1,

    // TLB write port
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic [18:0]   w_vpn2,
    output logic [7:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_pfn0,
    output logic [2:0]    w_c0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_pfn1,
    output logic [2:0]    w_c1,
    output logic          w_d1,
    output logic          w_v1
);

    // operation encodings
    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    // CP0 register addresses
    localparam logic [4:0] ADDR_INDEX    = 5'd0;
    localparam logic [4:0] ADDR_RANDOM   = 5'd1;
    localparam logic [4:0] ADDR_ENTRYLO0 = 5'd2;
    localparam logic [4:0] ADDR_ENTRYLO1 = 5'd3;
    localparam logic [4:0] ADDR_ENTRYHI  = 5'd10;

    localparam logic [IW-1:0] RAND_MAX  = IW'(TLBNUM - 1);
    localparam logic [IW-1:0] RAND_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO  = {IW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // FSM state and registered handshake/write-strobe outputs
    state_t        r_state;
    logic [1:0]    r_op;
    logic          r_op_ready;
    logic          r_op_done;
    logic          r_we;
    logic [IW-1:0] r_rand_snap;

    // CP0 register fields (only implemented bits are stored)
    logic          r_idx_p;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_random;
    logic [18:0]   r_hi_vpn2;
    logic [7:0]    r_hi_asid;
    logic [19:0]   r_lo0_pfn;
    logic [2:0]    r_lo0_c;
    logic          r_lo0_d;
    logic          r_lo0_v;
    logic          r_lo0_g;
    logic [19:0]   r_lo1_pfn;
    logic [2:0]    r_lo1_c;
    logic          r_lo1_d;
    logic          r_lo1_v;
    logic          r_lo1_g;

    logic          w_accept;
    logic          w_mtc0_en;
    logic          w_exec_tlbp;
    logic          w_exec_tlbr;
    logic [31:0]   w_mfc0_rdata;

    // Handshake and gating terms.
    // mtc0 writes land only while idle, so an operation in flight always
    // sees a stable register image.
    assign w_accept    = op_valid & r_op_ready;
    assign w_mtc0_en   = mtc0_we & (r_state == ST_IDLE);
    assign w_exec_tlbp = (r_state == ST_EXEC) & (r_op == OP_TLBP);
    assign w_exec_tlbr = (r_state == ST_EXEC) & (r_op == OP_TLBR);

    // Operation sequencer: IDLE -> EXEC -> DONE -> IDLE with registered strobes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_TLBP;
            r_op_ready  <= 1'b1;
            r_op_done   <= 1'b0;
            r_we        <= 1'b0;
            r_rand_snap <= IDX_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_op_done <= 1'b0;
                    if (w_accept) begin
                        r_op        <= op_type;
                        r_rand_snap <= r_random;
                        r_state     <= ST_EXEC;
                        r_op_ready  <= 1'b0;
                        // TLBWI/TLBWR both have op_type[1] set
                        r_we        <= op_type[1];
                    end else begin
                        r_state    <= ST_IDLE;
                        r_op_ready <= 1'b1;
                        r_we       <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    r_state   <= ST_DONE;
                    r_we      <= 1'b0;
                    r_op_done <= 1'b1;
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_op_done  <= 1'b0;
                    r_op_ready <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_op_done  <= 1'b0;
                    r_op_ready <= 1'b1;
                    r_we       <= 1'b0;
                end
            endcase
        end
    end

    // Random counts down every cycle and wraps from 0 back to TLBNUM-1
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_random <= RAND_MAX;
        end else if (r_random == IDX_ZERO) begin
            r_random <= RAND_MAX;
        end else begin
            r_random <= r_random - RAND_ONE;
        end
    end

    // CP0 register file.
    // An operation's EXEC-cycle update outranks any mtc0 write in the same
    // cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx_p   <= 1'b0;
            r_idx     <= IDX_ZERO;
            r_hi_vpn2 <= 19'd0;
            r_hi_asid <= 8'd0;
            r_lo0_pfn <= 20'd0;
            r_lo0_c   <= 3'd0;
            r_lo0_d   <= 1'b0;
            r_lo0_v   <= 1'b0;
            r_lo0_g   <= 1'b0;
            r_lo1_pfn <= 20'd0;
            r_lo1_c   <= 3'd0;
            r_lo1_d   <= 1'b0;
            r_lo1_v   <= 1'b0;
            r_lo1_g   <= 1'b0;
        end else if (w_exec_tlbp) begin
            // probe: P flags a miss, index only moves on a hit
            r_idx_p <= ~s_found;
            r_idx   <= s_found ? s_index : r_idx;
        end else if (w_exec_tlbr) begin
            r_hi_vpn2 <= r_vpn2;
            r_hi_asid <= r_asid;
            r_lo0_pfn <= r_pfn0;
            r_lo0_c   <= r_c0;
            r_lo0_d   <= r_d0;
            r_lo0_v   <= r_v0;
            r_lo0_g   <= r_g;
            r_lo1_pfn <= r_pfn1;
            r_lo1_c   <= r_c1;
            r_lo1_d   <= r_d1;
            r_lo1_v   <= r_v1;
            r_lo1_g   <= r_g;
        end else if (w_mtc0_en) begin
            case (mtc0_addr)
                ADDR_INDEX: begin
                    r_idx_p <= mtc0_wdata[31];
                    r_idx   <= mtc0_wdata[IW-1:0];
                end
                ADDR_ENTRYLO0: begin
                    r_lo0_pfn <= mtc0_wdata[25:6];
                    r_lo0_c   <= mtc0_wdata[5:3];
                    r_lo0_d   <= mtc0_wdata[2];
                    r_lo0_v   <= mtc0_wdata[1];
                    r_lo0_g   <= mtc0_wdata[0];
                end
                ADDR_ENTRYLO1: begin
                    r_lo1_pfn <= mtc0_wdata[25:6];
                    r_lo1_c   <= mtc0_wdata[5:3];
                    r_lo1_d   <= mtc0_wdata[2];
                    r_lo1_v   <= mtc0_wdata[1];
                    r_lo1_g   <= mtc0_wdata[0];
                end
                ADDR_ENTRYHI: begin
                    r_hi_vpn2 <= mtc0_wdata[31:13];
                    r_hi_asid <= mtc0_wdata[7:0];
                end
                default: begin
                    // Random and unknown addresses are not writable
                end
            endcase
        end else begin
            r_idx_p <= r_idx_p;
        end
    end

    // mfc0 read mux: unimplemented bits and unknown addresses read as zero
    always_comb begin
        w_mfc0_rdata = 32'h0000_0000;
        case (mfc0_addr)
            ADDR_INDEX:    w_mfc0_rdata = {r_idx_p, {(31 - IW){1'b0}}, r_idx};
            ADDR_RANDOM:   w_mfc0_rdata = {{(32 - IW){1'b0}}, r_random};
            ADDR_ENTRYLO0: w_mfc0_rdata = {6'd0, r_lo0_pfn, r_lo0_c, r_lo0_d, r_lo0_v, r_lo0_g};
            ADDR_ENTRYLO1: w_mfc0_rdata = {6'd0, r_lo1_pfn, r_lo1_c, r_lo1_d, r_lo1_v, r_lo1_g};
            ADDR_ENTRYHI:  w_mfc0_rdata = {r_hi_vpn2, 5'd0, r_hi_asid};
            default:       w_mfc0_rdata = 32'h0000_0000;
        endcase
    end

    assign mfc0_rdata = w_mfc0_rdata;

    // handshake outputs
    assign op_ready = r_op_ready;
    assign op_done  = r_op_done;

    // search and read ports always follow EntryHi / Index
    assign s_vpn2  = r_hi_vpn2;
    assign s_asid  = r_hi_asid;
    assign r_index = r_idx;

    // Write port.
    // TLBWR uses the Random value captured at accept; TLBWI uses Index, which
    // already includes any mtc0 committed in the accept cycle.
    assign we      = r_we;
    assign w_index = (r_op == OP_TLBWR) ? r_rand_snap : r_idx;
    assign w_vpn2  = r_hi_vpn2;
    assign w_asid  = r_hi_asid;
    assign w_g     = r_lo0_g & r_lo1_g;
    assign w_pfn0  = r_lo0_pfn;
    assign w_c0    = r_lo0_c;
    assign w_d0    = r_lo0_d;
    assign w_v0    = r_lo0_v;
    assign w_pfn1  = r_lo1_pfn;
    assign w_c1    = r_lo1_c;
    assign w_d1    = r_lo1_d;
    assign w_v1    = r_lo1_v;

endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// tb_tlb_cp0_ctrl
// Directed self-checking bench for tlb_cp0_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tlb_cp0_ctrl;

    localparam int TLBNUM = 16;
    localparam int IW     = 4;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    logic          clk = 1'b0;
    logic          resetn;
    logic          op_valid;
    logic [1:0]    op_type;
    logic          op_ready;
    logic          op_done;
    logic          mtc0_we;
    logic [4:0]    mtc0_addr;
    logic [31:0]   mtc0_wdata;
    logic [4:0]    mfc0_addr;
    logic [31:0]   mfc0_rdata;
    logic [18:0]   s_vpn2;
    logic [7:0]    s_asid;
    logic          s_found;
    logic [IW-1:0] s_index;
    logic [IW-1:0] r_index;
    logic [18:0]   r_vpn2;
    logic [7:0]    r_asid;
    logic          r_g;
    logic [19:0]   r_pfn0;
    logic [2:0]    r_c0;
    logic          r_d0;
    logic          r_v0;
    logic [19:0]   r_pfn1;
    logic [2:0]    r_c1;
    logic          r_d1;
    logic          r_v1;
    logic          we;
    logic [IW-1:0] w_index;
    logic [18:0]   w_vpn2;
    logic [7:0]    w_asid;
    logic          w_g;
    logic [19:0]   w_pfn0;
    logic [2:0]    w_c0;
    logic          w_d0;
    logic          w_v0;
    logic [19:0]   w_pfn1;
    logic [2:0]    w_c1;
    logic          w_d1;
    logic          w_v1;

    // model TLB contents seen by the read port
    logic [18:0] m_vpn2 [TLBNUM];
    logic [7:0]  m_asid [TLBNUM];
    logic        m_g    [TLBNUM];
    logic [19:0] m_pfn0 [TLBNUM];
    logic [2:0]  m_c0   [TLBNUM];
    logic        m_d0   [TLBNUM];
    logic        m_v0   [TLBNUM];
    logic [19:0] m_pfn1 [TLBNUM];
    logic [2:0]  m_c1   [TLBNUM];
    logic        m_d1   [TLBNUM];
    logic        m_v1   [TLBNUM];

    assign r_vpn2 = m_vpn2[r_index];
    assign r_asid = m_asid[r_index];
    assign r_g    = m_g[r_index];
    assign r_pfn0 = m_pfn0[r_index];
    assign r_c0   = m_c0[r_index];
    assign r_d0   = m_d0[r_index];
    assign r_v0   = m_v0[r_index];
    assign r_pfn1 = m_pfn1[r_index];
    assign r_c1   = m_c1[r_index];
    assign r_d1   = m_d1[r_index];
    assign r_v1   = m_v1[r_index];

    int n_checks = 0;
    int n_fail   = 0;

    tlb_cp0_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready), .op_done(op_done),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
        .mfc0_addr(mfc0_addr), .mfc0_rdata(mfc0_rdata),
        .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1)
    );

    // 20 ns clock
    always #10 clk = ~clk;

    // single comparison point
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] data);
        mfc0_addr = addr;
        #1;
        data = mfc0_rdata;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        mtc0_we    = 1'b1;
        mtc0_addr  = addr;
        mtc0_wdata = data;
        @(negedge clk);
        mtc0_we    = 1'b0;
    endtask

    // present an op for one cycle; returns at the EXEC sample point
    task automatic issue(input logic [1:0] t);
        op_valid = 1'b1;
        op_type  = t;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // walk DONE then back to IDLE, checking the completion pulse
    task automatic finish_op(input string tag);
        @(negedge clk);
        check_val({tag, "_done"}, {31'd0, op_done}, 32'd1);
        check_val({tag, "_we_off"}, {31'd0, we}, 32'd0);
        @(negedge clk);
        check_val({tag, "_done_drop"}, {31'd0, op_done}, 32'd0);
        check_val({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
    endtask

    logic [31:0] d;

    initial begin
        resetn     = 1'b0;
        op_valid   = 1'b0;
        op_type    = 2'b00;
        mtc0_we    = 1'b0;
        mtc0_addr  = 5'd0;
        mtc0_wdata = 32'd0;
        mfc0_addr  = 5'd0;
        s_found    = 1'b0;
        s_index    = 4'd0;
        for (int i = 0; i < TLBNUM; i++) begin
            m_vpn2[i] = 19'(i * 3 + 1);
            m_asid[i] = 8'(i);
            m_g[i]    = 1'b0;
            m_pfn0[i] = 20'(i + 100);
            m_c0[i]   = 3'd1;
            m_d0[i]   = 1'b0;
            m_v0[i]   = 1'b0;
            m_pfn1[i] = 20'(i + 200);
            m_c1[i]   = 3'd1;
            m_d1[i]   = 1'b0;
            m_v1[i]   = 1'b0;
        end
        m_vpn2[5] = 19'h1ABCD;
        m_asid[5] = 8'h3C;
        m_g[5]    = 1'b1;
        m_pfn0[5] = 20'hABCDE;
        m_c0[5]   = 3'd3;
        m_d0[5]   = 1'b1;
        m_v0[5]   = 1'b1;
        m_pfn1[5] = 20'h12345;
        m_c1[5]   = 3'd2;
        m_d1[5]   = 1'b0;
        m_v1[5]   = 1'b1;

        repeat (2) @(negedge clk);

        // reset state
        check_val("rst_ready", {31'd0, op_ready}, 32'd1);
        check_val("rst_done", {31'd0, op_done}, 32'd0);
        check_val("rst_we", {31'd0, we}, 32'd0);
        rd(5'd0, d);  check_val("rst_index", d, 32'h0000_0000);
        rd(5'd10, d); check_val("rst_entryhi", d, 32'h0000_0000);
        rd(5'd2, d);  check_val("rst_entrylo0", d, 32'h0000_0000);
        rd(5'd1, d);  check_val("rst_random", d, 32'h0000_000F);

        // Random counts down and wraps 0 -> 15
        resetn = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            rd(5'd1, d);
            check_val("random_seq", d, (k == 16) ? 32'd15 : 32'(15 - k));
            @(negedge clk);
        end

        // TLBWR accepted after 4 idle cycles uses Random = 11
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        rd(5'd1, d); check_val("wr_random_pre", d, 32'd11);
        issue(OP_TLBWR);
        check_val("tlbwr_we", {31'd0, we}, 32'd1);
        check_val("tlbwr_index", {28'd0, w_index}, 32'd11);
        check_val("tlbwr_busy", {31'd0, op_ready}, 32'd0);
        check_val("tlbwr_nodone", {31'd0, op_done}, 32'd0);
        finish_op("tlbwr");

        // field masking and unknown addresses
        wr(5'd10, 32'hFFFF_FFFF);
        rd(5'd10, d); check_val("mask_entryhi", d, 32'hFFFF_E0FF);
        wr(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, d);  check_val("mask_index", d, 32'h8000_000F);
        wr(5'd2, 32'hFFFF_FFFF);
        rd(5'd2, d);  check_val("mask_entrylo0", d, 32'h03FF_FFFF);
        wr(5'd5, 32'h1234_5678);
        rd(5'd5, d);  check_val("unknown_addr", d, 32'h0000_0000);

        // TLBWI from mtc0-loaded registers
        wr(5'd10, 32'h0040_2005);
        wr(5'd2, 32'h0000_1047);
        wr(5'd3, 32'h0000_2047);
        wr(5'd0, 32'h0000_0003);
        rd(5'd10, d); check_val("rb_entryhi", d, 32'h0040_2005);
        rd(5'd2, d);  check_val("rb_entrylo0", d, 32'h0000_1047);
        rd(5'd3, d);  check_val("rb_entrylo1", d, 32'h0000_2047);
        check_val("pre_wi_we", {31'd0, we}, 32'd0);
        issue(OP_TLBWI);
        check_val("wi_we", {31'd0, we}, 32'd1);
        check_val("wi_nodone", {31'd0, op_done}, 32'd0);
        check_val("wi_index", {28'd0, w_index}, 32'd3);
        check_val("wi_vpn2", {13'd0, w_vpn2}, 32'h0000_0201);
        check_val("wi_asid", {24'd0, w_asid}, 32'h0000_0005);
        check_val("wi_pfn0", {12'd0, w_pfn0}, 32'h0000_0041);
        check_val("wi_pfn1", {12'd0, w_pfn1}, 32'h0000_0081);
        check_val("wi_g", {31'd0, w_g}, 32'd1);
        check_val("wi_lo0_cdv", {28'd0, w_c0, w_d0, w_v0}, 32'h0000_0003);
        finish_op("tlbwi");

        // search port follows EntryHi
        check_val("s_vpn2", {13'd0, s_vpn2}, 32'h0000_0201);
        check_val("s_asid", {24'd0, s_asid}, 32'h0000_0005);

        // TLBP hit then miss
        wr(5'd0, 32'h0000_0007);
        s_found = 1'b1;
        s_index = 4'd3;
        issue(OP_TLBP);
        finish_op("tlbp_hit");
        rd(5'd0, d); check_val("tlbp_hit_index", d, 32'h0000_0003);
        s_found = 1'b0;
        s_index = 4'd9;
        issue(OP_TLBP);
        finish_op("tlbp_miss");
        rd(5'd0, d); check_val("tlbp_miss_index", d, 32'h8000_0003);

        // TLBR of model entry 5
        wr(5'd0, 32'h0000_0005);
        check_val("tlbr_r_index", {28'd0, r_index}, 32'd5);
        issue(OP_TLBR);
        check_val("tlbr_no_we", {31'd0, we}, 32'd0);
        finish_op("tlbr");
        rd(5'd10, d); check_val("tlbr_entryhi", d, 32'h3579_A03C);
        rd(5'd2, d);  check_val("tlbr_entrylo0", d, 32'h02AF_379F);
        rd(5'd3, d);  check_val("tlbr_entrylo1", d, 32'h0048_D153);

        // mtc0 during EXEC/DONE is dropped
        issue(OP_TLBWI);
        mtc0_we    = 1'b1;
        mtc0_addr  = 5'd0;
        mtc0_wdata = 32'h0000_0009;
        check_val("busy_wi_index", {28'd0, w_index}, 32'd5);
        check_val("busy_wi_g", {31'd0, w_g}, 32'd1);
        @(negedge clk);
        check_val("busy_done", {31'd0, op_done}, 32'd1);
        @(negedge clk);
        mtc0_we = 1'b0;
        rd(5'd0, d); check_val("busy_mtc0_dropped", d, 32'h0000_0005);

        // mtc0 in the accept cycle is visible to EXEC
        mtc0_we    = 1'b1;
        mtc0_addr  = 5'd0;
        mtc0_wdata = 32'h0000_000A;
        issue(OP_TLBWI);
        mtc0_we = 1'b0;
        check_val("same_cyc_we", {31'd0, we}, 32'd1);
        check_val("same_cyc_index", {28'd0, w_index}, 32'd10);
        finish_op("same_cyc");

        // reset during EXEC of TLBWI abandons the op
        issue(OP_TLBWI);
        check_val("abort_we_pre", {31'd0, we}, 32'd1);
        resetn = 1'b0;
        #1;
        check_val("abort_we", {31'd0, we}, 32'd0);
        check_val("abort_ready", {31'd0, op_ready}, 32'd1);
        check_val("abort_done", {31'd0, op_done}, 32'd0);
        rd(5'd0, d);  check_val("abort_index", d, 32'h0000_0000);
        rd(5'd10, d); check_val("abort_entryhi", d, 32'h0000_0000);
        rd(5'd3, d);  check_val("abort_entrylo1", d, 32'h0000_0000);
        rd(5'd1, d);  check_val("abort_random", d, 32'h0000_000F);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("abort_no_done", {31'd0, op_done}, 32'd0);
            check_val("abort_no_we", {31'd0, we}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tlb_cp0_ctrl.md
TLB_CP0_CTRL -- requirements
Module: tlb_cp0_ctrl

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, giving the TLB entry count; the index width is IW = $clog2(TLBNUM).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have op_valid (in, 1), op_type (in, 2: 00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR), op_ready (out, 1) and op_done (out, 1, one-cycle completion pulse).
REQ-005 SHALL have mtc0_we (in, 1), mtc0_addr (in, 5), mtc0_wdata (in, 32), mfc0_addr (in, 5) and mfc0_rdata (out, 32, combinational).
REQ-006 SHALL have the search outputs s_vpn2 (out, 19) and s_asid (out, 8), and the search inputs s_found (in, 1) and s_index (in, IW).
REQ-007 SHALL have the read-port output r_index (out, IW), plus the read-port inputs r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1 and r_v1, each with the TLB field width.
REQ-008 SHALL have the write-port outputs we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1 and w_v1, each with the TLB field width.

Function
REQ-009 SHALL hold these CP0 registers: Index (addr 0; P at bit 31, index at [IW-1:0]), Random (addr 1, read-only), EntryLo0/EntryLo1 (addr 2/3; PFN [25:6], C [5:3], D [2], V [1], G [0]) and EntryHi (addr 10; VPN2 [31:13], ASID [7:0]).
REQ-010 SHALL return the register image on mfc0_rdata, with unimplemented bits and unknown addresses reading as 0.
REQ-011 SHALL drive s_vpn2 = EntryHi[31:13] and s_asid = EntryHi[7:0] at all times, and r_index = Index[IW-1:0] at all times.
REQ-012 SHALL implement the FSM states IDLE, EXEC and DONE, with op_ready = (state == IDLE).
REQ-013 SHALL accept an operation when op_valid && op_ready: latch op_type, then IDLE->EXEC.
REQ-014 SHALL always transition EXEC->DONE, then DONE->IDLE, and assert op_done only in DONE; the latency from accept to op_done is 2 cycles, with the next accept possible 3 cycles after the previous one.
REQ-015 SHALL, for TLBP, at the end of EXEC load Index.P = !s_found and Index[IW-1:0] = s_found ? s_index : unchanged.
REQ-016 SHALL, for TLBR, at the end of EXEC load EntryHi {r_vpn2, r_asid}, EntryLo0 {r_pfn0, r_c0, r_d0, r_v0, r_g} and EntryLo1 {r_pfn1, r_c1, r_d1, r_v1, r_g}.
REQ-017 SHALL, for TLBWI/TLBWR, assert we for exactly the EXEC cycle only.
REQ-018 SHALL, during that write cycle, drive w_index = Index[IW-1:0] (TLBWI) or the Random value sampled at accept (TLBWR).
REQ-019 SHALL drive the w_* fields from EntryHi/EntryLo0/EntryLo1, with w_g = EntryLo0.G & EntryLo1.G.
REQ-020 SHALL hold we at 0 in all other cycles.
REQ-021 SHALL decrement Random every cycle, wrapping from 0 to TLBNUM-1.
REQ-022 SHALL apply an mtc0 write only when state == IDLE; mtc0 writes while in EXEC or DONE are dropped.
REQ-023 SHALL, on mtc0 to Index, write only P and the index bits.
REQ-024 SHALL, on mtc0 to EntryHi/EntryLo, write only the defined fields; writes to Random are ignored.
REQ-025 SHALL, when an mtc0 write and an op accept occur in the same IDLE cycle, commit the write first so that EXEC uses the new value.
REQ-026 SHALL, when an op's own EXEC update and an mtc0 write coincide, give the op update priority (impossible by REQ-022, but stated for completeness).

Reset
REQ-027 SHALL, while resetn = 0, immediately force: state IDLE, op_ready 1, op_done 0, we 0, Index/EntryHi/EntryLo0/EntryLo1 = 0, and Random = TLBNUM-1.
REQ-028 SHALL, on reset mid-operation, abandon the operation with no write pulse and no op_done.

Verification
REQ-029 SHALL be covered by a test: mtc0 EntryHi=0x0040_2005, EntryLo0=0x0000_1047, EntryLo1=0x0000_2047, Index=3, then TLBWI -> one we pulse with w_index=3, w_vpn2=0x00201, w_asid=0x05, w_pfn0=0x00041, w_pfn1=0x00081, w_g=1, and op_done 2 cycles after accept.
REQ-030 SHALL be covered by a test: TLBP with s_found=1, s_index=3 -> Index reads 0x0000_0003; TLBP with s_found=0 -> Index reads 0x8000_0003.
REQ-031 SHALL be covered by a test: TLBR with Index=5 and the r_* inputs from a model TLB entry 5 -> r_index=5 and EntryHi/EntryLo0/EntryLo1 match the entry, with G copied into both EntryLo registers.
REQ-032 SHALL be covered by a test: TLBWR after reset plus 4 idle cycles, accepted on cycle 4 -> w_index=TLBNUM-1-4=11; also check Random wraps 0->15.
REQ-033 SHALL be covered by a test: mtc0 Index issued during EXEC -> Index unchanged; mtc0 in the same cycle as an accepted TLBWI -> the new Index is used for w_index.
REQ-034 SHALL be covered by a test: resetn deasserted during EXEC of TLBWI -> we drops to 0 at once, no op_done, registers zeroed and Random = 15.
